// File: rtl/decode_pipe_pkg.sv
// Shared definitions for the decode stage: opcodes, decode select enums,
// FSM states and the opcode-to-control decoding function.
package decode_pipe_pkg;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00100;
    localparam logic [4:0] OP_JR   = 5'b00101;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;
    localparam logic [4:0] OP_ST   = 5'b10000;
    localparam logic [4:0] OP_LD   = 5'b10001;
    localparam logic [4:0] OP_SLBI = 5'b10010;
    localparam logic [4:0] OP_STU  = 5'b10011;
    localparam logic [4:0] OP_LBI  = 5'b11000;
    localparam logic [4:0] OP_BTR  = 5'b11001;
    localparam logic [4:0] OP_ADD  = 5'b11011;

    typedef enum logic [2:0] {
        DST_NONE,
        DST_RD_R,
        DST_RD_I,
        DST_RS,
        DST_RET
    } dst_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM5_S,
        IMM5_Z,
        IMM8_S,
        IMM8_Z,
        IMM11_S
    } imm_sel_e;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        HALT
    } state_e;

    typedef struct packed {
        dst_sel_e dst;
        imm_sel_e imm;
        logic     mem_read;
        logic     mem_write;
    } ctrl_t;

    // Map an opcode onto destination/immediate selection and memory controls.
    // HALT, NOP, SIIC and RTI fall through to the all-zero default.
    function automatic ctrl_t decode_ctrl(input logic [4:0] op);
        ctrl_t c;
        c.dst       = DST_NONE;
        c.imm       = IMM_NONE;
        c.mem_read  = 1'b0;
        c.mem_write = 1'b0;
        casez (op)
            OP_J:     c.imm = IMM11_S;
            OP_JR:    c.imm = IMM8_S;
            OP_JAL:   begin c.imm = IMM11_S; c.dst = DST_RET; end
            OP_JALR:  begin c.imm = IMM8_S;  c.dst = DST_RET; end
            5'b0100?: begin c.imm = IMM5_S;  c.dst = DST_RD_I; end
            5'b0101?: begin c.imm = IMM5_Z;  c.dst = DST_RD_I; end
            5'b011??: c.imm = IMM8_S;
            OP_ST:    begin c.imm = IMM5_S;  c.mem_write = 1'b1; end
            OP_LD:    begin c.imm = IMM5_S;  c.dst = DST_RD_I; c.mem_read = 1'b1; end
            OP_SLBI:  begin c.imm = IMM8_Z;  c.dst = DST_RS; end
            OP_STU:   begin c.imm = IMM5_S;  c.dst = DST_RS; c.mem_write = 1'b1; end
            5'b101??: begin c.imm = IMM5_Z;  c.dst = DST_RD_I; end
            OP_LBI:   begin c.imm = IMM8_S;  c.dst = DST_RS; end
            OP_BTR:   c.dst = DST_RD_R;
            5'b1101?: c.dst = DST_RD_R;
            5'b111??: c.dst = DST_RD_R;
            default:  ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_pipe_rf.sv
// Parametrised register file with two combinational read ports. A write and a
// read of the same register in one cycle return the incoming write data.
module rf_bypass_param #(
    parameter int  W    = 16,
    parameter int  NREG = 8,
    localparam int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_sel,
    input  logic [W-1:0]  wr_data,
    input  logic [RW-1:0] rd_sel1,
    input  logic [RW-1:0] rd_sel2,
    output logic [W-1:0]  rd_data1,
    output logic [W-1:0]  rd_data2
);

    logic [W-1:0] regs [NREG];

    // Clear every register on reset, otherwise write the selected register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_sel] <= wr_data;
        end
    end

    assign rd_data1 = (wr_en && (wr_sel == rd_sel1)) ? wr_data : regs[rd_sel1];
    assign rd_data2 = (wr_en && (wr_sel == rd_sel2)) ? wr_data : regs[rd_sel2];

endmodule

// File: rtl/decode_pipe.sv
// Instruction decode stage: reads operands, extends immediates, picks the
// destination register and holds the result in a valid/ready ID/EX register.
// Load-use hazards insert exactly one bubble; HALT freezes intake until reset.
module decode_pipe #(
    parameter int  N       = 16,
    parameter int  NREG    = 8,
    parameter int  RET_REG = 7,
    localparam int RW      = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_instr,
    input  logic [N-1:0]  in_pcplus2,
    input  logic          flush,
    input  logic          wb_en,
    input  logic [RW-1:0] wb_sel,
    input  logic [N-1:0]  wb_data,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [N-1:0]  ex_instr,
    output logic [N-1:0]  ex_rd1,
    output logic [N-1:0]  ex_rd2,
    output logic [N-1:0]  ex_imm,
    output logic [N-1:0]  ex_pcplus2,
    output logic [RW-1:0] ex_wsel,
    output logic          ex_we,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          halted,
    output logic          err
);

    import decode_pipe_pkg::*;

    localparam logic BAD_PARAMS = (N < 16) || (NREG < 2) || (RET_REG < 0) || (RET_REG >= NREG);

    state_e        state, state_d;
    ctrl_t         ctrl;
    logic [4:0]    opcode;
    logic [RW-1:0] rs_sel, rt_sel;
    logic [N-1:0]  rd1, rd2;
    logic [N-1:0]  imm_d;
    logic [RW-1:0] wsel_d;
    logic          we_d;
    logic          hazard;
    logic          take;

    assign opcode = in_instr[15:11];
    assign rs_sel = RW'(in_instr[10:8]);
    assign rt_sel = RW'(in_instr[7:5]);
    assign ctrl   = decode_ctrl(opcode);

    rf_bypass_param #(
        .W    (N),
        .NREG (NREG)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wb_en),
        .wr_sel   (wb_sel),
        .wr_data  (wb_data),
        .rd_sel1  (rs_sel),
        .rd_sel2  (rt_sel),
        .rd_data1 (rd1),
        .rd_data2 (rd2)
    );

    // Destination register and write enable from the decoded destination class.
    always_comb begin
        wsel_d = '0;
        we_d   = 1'b0;
        case (ctrl.dst)
            DST_RD_R: begin wsel_d = RW'(in_instr[4:2]);  we_d = 1'b1; end
            DST_RD_I: begin wsel_d = RW'(in_instr[7:5]);  we_d = 1'b1; end
            DST_RS:   begin wsel_d = RW'(in_instr[10:8]); we_d = 1'b1; end
            DST_RET:  begin wsel_d = RW'(RET_REG);        we_d = 1'b1; end
            default:  ;
        endcase
    end

    // Immediate field extension to the datapath width.
    always_comb begin
        imm_d = '0;
        case (ctrl.imm)
            IMM5_S:  imm_d = N'($signed(in_instr[4:0]));
            IMM5_Z:  imm_d = N'(in_instr[4:0]);
            IMM8_S:  imm_d = N'($signed(in_instr[7:0]));
            IMM8_Z:  imm_d = N'(in_instr[7:0]);
            IMM11_S: imm_d = N'($signed(in_instr[10:0]));
            default: ;
        endcase
    end

    // A load still in ID/EX whose destination feeds this instruction must not be
    // bypassed; the consumer waits for one bubble behind the load.
    assign hazard   = ex_valid & ex_memread & ex_we & ((ex_wsel == rs_sel) | (ex_wsel == rt_sel));
    assign in_ready = (state == RUN) & ~hazard & (~ex_valid | ex_ready);
    assign take     = in_valid & in_ready & ~flush;
    assign halted   = (state == HALT);

    // Next-state logic. A hazard whose load drains this cycle gets its bubble
    // at this edge, so STALL is only entered while the load is still held.
    always_comb begin
        state_d = state;
        case (state)
            RUN: begin
                if (take && (opcode == OP_HALT)) begin
                    state_d = HALT;
                end else if (in_valid && hazard && !ex_ready && !flush) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (flush || ex_ready) begin
                    state_d = RUN;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_d;
        end
    end

    // ID/EX register: loads when empty or draining, holds while stalled by
    // execute, and is emptied by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_instr    <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_pcplus2  <= '0;
            ex_wsel     <= '0;
            ex_we       <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_we       <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
        end else if (!ex_valid || ex_ready) begin
            ex_valid <= take;
            if (take) begin
                ex_instr    <= in_instr;
                ex_rd1      <= rd1;
                ex_rd2      <= rd2;
                ex_imm      <= imm_d;
                ex_pcplus2  <= in_pcplus2;
                ex_wsel     <= wsel_d;
                ex_we       <= we_d;
                ex_memread  <= ctrl.mem_read;
                ex_memwrite <= ctrl.mem_write;
            end else begin
                ex_we       <= 1'b0;
                ex_memread  <= 1'b0;
                ex_memwrite <= 1'b0;
            end
        end
    end

    // Error flag reports an unusable parameter set once out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= BAD_PARAMS;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: a table of decoded instructions checked through a
// scoreboard, plus hand sequences for bypass, load-use, backpressure, flush,
// halt/reset and a wide-parameter instance.
module tb_decode_pipe;

    typedef struct packed {
        logic [15:0] instr;
        logic [2:0]  wsel;
        logic        we;
        logic        mr;
        logic        mw;
        logic [15:0] imm;
    } vec_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] imm;
        logic [15:0] pc;
        logic [2:0]  wsel;
        logic        we;
        logic        mr;
        logic        mw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, wb_en, ex_valid, ex_ready;
    logic [15:0] in_instr, in_pcplus2, wb_data;
    logic [2:0]  wb_sel, ex_wsel;
    logic [15:0] ex_instr, ex_rd1, ex_rd2, ex_imm, ex_pcplus2;
    logic        ex_we, ex_memread, ex_memwrite, halted, err;

    logic        b_in_valid, b_in_ready, b_flush, b_wb_en, b_ex_valid, b_ex_ready;
    logic [31:0] b_in_instr, b_in_pcplus2, b_wb_data;
    logic [3:0]  b_wb_sel, b_ex_wsel;
    logic [31:0] b_ex_instr, b_ex_rd1, b_ex_rd2, b_ex_imm, b_ex_pcplus2;
    logic        b_ex_we, b_ex_memread, b_ex_memwrite, b_halted, b_err;

    int          compared = 0;
    int          failed   = 0;
    exp_t        sb[$];
    exp_t        cur_exp;
    logic [15:0] rf_model [8];
    logic        last_accept;
    vec_t        tbl [13];

    localparam vec_t ADD_R3 = '{16'hDB28, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0000};
    localparam vec_t LD_R2  = '{16'h8940, 3'd2, 1'b1, 1'b1, 1'b0, 16'h0000};
    localparam vec_t ADD_R2 = '{16'hDA30, 3'd4, 1'b1, 1'b0, 1'b0, 16'h0000};
    localparam vec_t HALT_V = '{16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000};
    localparam vec_t NOP_V  = '{16'h0800, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000};

    always #5 clk = ~clk;

    decode_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pcplus2(in_pcplus2), .flush(flush),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pcplus2(ex_pcplus2),
        .ex_wsel(ex_wsel), .ex_we(ex_we), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .halted(halted), .err(err)
    );

    decode_pipe #(.N(32), .NREG(16)) dut_wide (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_pcplus2(b_in_pcplus2), .flush(b_flush),
        .wb_en(b_wb_en), .wb_sel(b_wb_sel), .wb_data(b_wb_data),
        .ex_valid(b_ex_valid), .ex_ready(b_ex_ready), .ex_instr(b_ex_instr),
        .ex_rd1(b_ex_rd1), .ex_rd2(b_ex_rd2), .ex_imm(b_ex_imm), .ex_pcplus2(b_ex_pcplus2),
        .ex_wsel(b_ex_wsel), .ex_we(b_ex_we), .ex_memread(b_ex_memread),
        .ex_memwrite(b_ex_memwrite), .halted(b_halted), .err(b_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input logic [15:0] pc);
        in_valid      = 1'b1;
        in_instr      = v.instr;
        in_pcplus2    = pc;
        cur_exp       = '0;
        cur_exp.instr = v.instr;
        cur_exp.imm   = v.imm;
        cur_exp.pc    = pc;
        cur_exp.wsel  = v.wsel;
        cur_exp.we    = v.we;
        cur_exp.mr    = v.mr;
        cur_exp.mw    = v.mw;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Sample at the falling edge: retire issued instructions against the
    // scoreboard, record accepted ones, and track register writes.
    task automatic checkOutput();
        exp_t        a, e;
        logic [2:0]  rs, rt;
        @(negedge clk);
        last_accept = 1'b0;
        if (rst) begin
            sb.delete();
            for (int i = 0; i < 8; i++) rf_model[i] = '0;
            return;
        end
        a = '{ex_instr, ex_rd1, ex_rd2, ex_imm, ex_pcplus2, ex_wsel, ex_we, ex_memread, ex_memwrite};
        if (ex_valid && ex_ready) begin
            compared++;
            if (sb.size() == 0) begin
                failed++;
                $display("[TB] FAIL issue: got instr %h with nothing expected", ex_instr);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    failed++;
                    $display("[TB] FAIL issue: got %h expected %h", a, e);
                end
            end
        end else if (ex_valid && flush && sb.size() > 0) begin
            void'(sb.pop_front());
        end
        if (in_valid && in_ready && !flush) begin
            last_accept = 1'b1;
            rs = in_instr[10:8];
            rt = in_instr[7:5];
            cur_exp.rd1 = (wb_en && wb_sel == rs) ? wb_data : rf_model[rs];
            cur_exp.rd2 = (wb_en && wb_sel == rt) ? wb_data : rf_model[rt];
            sb.push_back(cur_exp);
        end
        if (wb_en) rf_model[wb_sel] = wb_data;
    endtask

    initial begin
        tbl[0]  = '{16'hD94C, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{16'h41BD, 3'd5, 1'b1, 1'b0, 1'b0, 16'hFFFD};
        tbl[2]  = '{16'h529F, 3'd4, 1'b1, 1'b0, 1'b0, 16'h001F};
        tbl[3]  = '{16'h8BC4, 3'd6, 1'b1, 1'b1, 1'b0, 16'h0004};
        tbl[4]  = '{16'h815F, 3'd0, 1'b0, 1'b0, 1'b1, 16'hFFFF};
        tbl[5]  = '{16'h6180, 3'd0, 1'b0, 1'b0, 1'b0, 16'hFF80};
        tbl[6]  = '{16'hC27F, 3'd2, 1'b1, 1'b0, 1'b0, 16'h007F};
        tbl[7]  = '{16'h94F0, 3'd4, 1'b1, 1'b0, 1'b0, 16'h00F0};
        tbl[8]  = '{16'h3400, 3'd7, 1'b1, 1'b0, 1'b0, 16'hFC00};
        tbl[9]  = '{16'h23FF, 3'd0, 1'b0, 1'b0, 1'b0, 16'h03FF};
        tbl[10] = '{16'h3B05, 3'd7, 1'b1, 1'b0, 1'b0, 16'h0005};
        tbl[11] = '{16'hAF2F, 3'd1, 1'b1, 1'b0, 1'b0, 16'h000F};
        tbl[12] = NOP_V;

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pcplus2 = '0; flush = 1'b0;
        wb_en = 1'b0; wb_sel = '0; wb_data = '0; ex_ready = 1'b1; cur_exp = '0;
        b_in_valid = 1'b0; b_in_instr = '0; b_in_pcplus2 = '0; b_flush = 1'b0;
        b_wb_en = 1'b0; b_wb_sel = '0; b_wb_data = '0; b_ex_ready = 1'b1;
        for (int i = 0; i < 8; i++) rf_model[i] = '0;

        repeat (2) begin checkOutput(); nextCycle(); end
        // a write during reset must not land
        wb_en = 1'b1; wb_sel = 3'd1; wb_data = 16'hBEEF;
        checkOutput(); nextCycle();
        rst = 1'b0; wb_en = 1'b0;
        checkOutput();
        check("reset ex_valid", 32'(ex_valid), 32'd0);
        check("reset halted", 32'(halted), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset err", 32'(err), 32'd0);
        check("reset ex_instr", 32'(ex_instr), 32'd0);
        check("reset ex_imm", 32'(ex_imm), 32'd0);
        check("reset ex_we", 32'(ex_we), 32'd0);
        nextCycle();

        // wide instance: JAL links to r7 and sign-extends 0x400 to 32 bits
        b_in_valid = 1'b1; b_in_instr = 32'h0000_3400; b_in_pcplus2 = 32'h0000_1002;
        checkOutput();
        check("wide in_ready", 32'(b_in_ready), 32'd1);
        nextCycle();
        b_in_valid = 1'b0;
        checkOutput();
        check("wide ex_valid", 32'(b_ex_valid), 32'd1);
        check("wide ex_wsel", 32'(b_ex_wsel), 32'd7);
        check("wide ex_we", 32'(b_ex_we), 32'd1);
        check("wide ex_imm", b_ex_imm, 32'hFFFF_FC00);
        check("wide ex_pcplus2", b_ex_pcplus2, 32'h0000_1002);
        nextCycle();

        for (int r = 2; r < 8; r++) begin
            wb_en = 1'b1; wb_sel = 3'(r); wb_data = 16'(16'h1111 * r);
            checkOutput(); nextCycle();
        end
        wb_en = 1'b0;

        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 13; i++) begin
                int tries;
                applyStimulus(tbl[i], 16'(16'h0100 + 2 * i + 64 * pass));
                tries = 0;
                do begin
                    ex_ready = (pass == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    checkOutput(); nextCycle();
                    tries++;
                end while (!last_accept && tries < 50);
                if (!last_accept) begin
                    compared++; failed++;
                    $display("[TB] FAIL accept: row %0d not taken after %0d cycles, required 1 accept", i, tries);
                end
            end
            in_valid = 1'b0; ex_ready = 1'b1;
            for (int k = 0; k < 20 && sb.size() > 0; k++) begin checkOutput(); nextCycle(); end
            check("table drain", 32'(sb.size()), 32'd0);
        end

        // writeback bypass into an ADD reading r3 in the same cycle
        wb_en = 1'b1; wb_sel = 3'd3; wb_data = 16'h1234;
        applyStimulus(ADD_R3, 16'h0200);
        checkOutput();
        check("bypass accept", 32'(in_ready), 32'd1);
        nextCycle();
        wb_en = 1'b0; in_valid = 1'b0;
        checkOutput();
        check("bypass rd1", 32'(ex_rd1), 32'h1234);
        nextCycle();

        // load-use back to back: one ready-low cycle, one bubble
        applyStimulus(LD_R2, 16'h0210);
        checkOutput();
        check("ld accept", 32'(in_ready), 32'd1);
        nextCycle();
        applyStimulus(ADD_R2, 16'h0212);
        checkOutput();
        check("hazard in_ready", 32'(in_ready), 32'd0);
        check("hazard ld issued", 32'(ex_valid), 32'd1);
        nextCycle();
        checkOutput();
        check("hazard bubble", 32'(ex_valid), 32'd0);
        check("hazard resume", 32'(in_ready), 32'd1);
        nextCycle();
        in_valid = 1'b0;
        checkOutput();
        check("hazard add valid", 32'(ex_valid), 32'd1);
        check("hazard add instr", 32'(ex_instr), 32'hDA30);
        nextCycle();

        // execute backpressure for three cycles
        ex_ready = 1'b0;
        applyStimulus(tbl[0], 16'h0220);
        checkOutput();
        check("hold first accept", 32'(in_ready), 32'd1);
        nextCycle();
        applyStimulus(tbl[2], 16'h0222);
        for (int k = 0; k < 3; k++) begin
            checkOutput();
            check("hold ex_instr", 32'(ex_instr), 32'hD94C);
            check("hold ex_pcplus2", 32'(ex_pcplus2), 32'h0220);
            check("hold in_ready", 32'(in_ready), 32'd0);
            nextCycle();
        end
        ex_ready = 1'b1;
        checkOutput(); nextCycle();
        in_valid = 1'b0;
        checkOutput(); nextCycle();
        check("hold no loss", 32'(sb.size()), 32'd0);

        // flush while stalled on a load-use hazard
        ex_ready = 1'b0;
        applyStimulus(LD_R2, 16'h0230);
        checkOutput(); nextCycle();
        applyStimulus(ADD_R2, 16'h0232);
        checkOutput();
        check("stall in_ready", 32'(in_ready), 32'd0);
        nextCycle();
        flush = 1'b1;
        checkOutput();
        check("stall flush in_ready", 32'(in_ready), 32'd0);
        nextCycle();
        flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
        checkOutput();
        check("flush ex_valid", 32'(ex_valid), 32'd0);
        check("flush back to run", 32'(in_ready), 32'd1);
        nextCycle();
        check("flush dropped", 32'(sb.size()), 32'd0);

        // HALT holds intake off, flush does not release it, reset does
        applyStimulus(HALT_V, 16'h0240);
        checkOutput();
        check("halt accept", 32'(in_ready), 32'd1);
        nextCycle();
        applyStimulus(NOP_V, 16'h0242);
        for (int k = 0; k < 4; k++) begin
            flush = (k == 1);
            checkOutput();
            check("halt halted", 32'(halted), 32'd1);
            check("halt in_ready", 32'(in_ready), 32'd0);
            nextCycle();
        end
        flush = 1'b0; rst = 1'b1;
        checkOutput(); nextCycle();
        rst = 1'b0; in_valid = 1'b0;
        checkOutput();
        check("halt reset halted", 32'(halted), 32'd0);
        check("halt reset ex_valid", 32'(ex_valid), 32'd0);
        check("halt reset in_ready", 32'(in_ready), 32'd1);
        nextCycle();

        // register file cleared by that reset
        applyStimulus(ADD_R3, 16'h0250);
        checkOutput(); nextCycle();
        in_valid = 1'b0;
        checkOutput();
        check("rf cleared rd1", 32'(ex_rd1), 32'd0);
        nextCycle();
        check("final drain", 32'(sb.size()), 32'd0);
        check("final err", 32'(err), 32'd0);
        check("final wide err", 32'(b_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
